// File: rtl/dmem_dual_issue_arbiter.sv
// dmem_dual_issue_arbiter: shares one data-memory port between two in-order MEM slots, serializing conflicting pairs
module dmem_dual_issue_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s0_pc,
  input  logic             s0_read,
  input  logic             s0_write,
  input  logic [1:0]       s0_width,
  input  logic             s0_unsigned,
  input  logic [31:0]      s0_addr,
  input  logic [31:0]      s0_wdata,
  input  logic [31:0]      s1_pc,
  input  logic             s1_read,
  input  logic             s1_write,
  input  logic [1:0]       s1_width,
  input  logic             s1_unsigned,
  input  logic [31:0]      s1_addr,
  input  logic [31:0]      s1_wdata,
  output logic [31:0]      m_pc,
  output logic [31:0]      m_addr,
  output logic             m_read,
  output logic             m_write,
  output logic [1:0]       m_width,
  output logic             m_unsigned,
  output logic [31:0]      m_wdata,
  output logic             m_is_inst1,
  input  logic [31:0]      m_rdata,
  output logic [31:0]      s0_rdata,
  output logic [31:0]      s1_rdata,
  output logic             stall,
  output logic [CNT_W-1:0] conflict_cnt
);
  typedef enum logic {IDLE, SECOND} state_t;
  state_t r_state, w_next;
  logic [31:0] r_h_pc, r_h_addr, r_h_wdata, r_hold0;
  logic [1:0] r_h_width;
  logic r_h_read, r_h_write, r_h_unsigned;
  logic [CNT_W-1:0] r_cnt;
  logic w_a0, w_a1, w_sec, w_pair, w_use1, w_rd, w_wr, w_act;
  always_comb begin
    w_a0 = s0_read | s0_write;
    w_a1 = s1_read | s1_write;
    w_sec = r_state == SECOND;
    w_pair = !w_sec & w_a0 & w_a1;
    w_use1 = w_sec | (!w_a0 & w_a1);
    w_rd = w_sec ? r_h_read : w_use1 ? s1_read : s0_read;
    w_wr = w_sec ? r_h_write : w_use1 ? s1_write : s0_write;
    w_act = !rst & (w_rd | w_wr);
    // a request with both read and write set is treated as a store
    m_read = w_act & w_rd & !w_wr;
    m_write = w_act & w_wr;
    m_is_inst1 = w_act & w_use1;
    m_pc = !w_act ? '0 : w_sec ? r_h_pc : w_use1 ? s1_pc : s0_pc;
    m_addr = !w_act ? '0 : w_sec ? r_h_addr : w_use1 ? s1_addr : s0_addr;
    m_wdata = !w_act ? '0 : w_sec ? r_h_wdata : w_use1 ? s1_wdata : s0_wdata;
    m_width = !w_act ? '0 : w_sec ? r_h_width : w_use1 ? s1_width : s0_width;
    m_unsigned = w_act & (w_sec ? r_h_unsigned : w_use1 ? s1_unsigned : s0_unsigned);
    stall = !rst & w_pair;
    s0_rdata = (w_sec & !rst) ? r_hold0 : (m_read & !m_is_inst1 & !stall) ? m_rdata : '0;
    s1_rdata = (m_read & m_is_inst1) ? m_rdata : '0;
    conflict_cnt = rst ? '0 : r_cnt;
    w_next = w_pair ? SECOND : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_h_pc <= '0;
      r_h_addr <= '0;
      r_h_wdata <= '0;
      r_h_width <= '0;
      r_h_read <= 1'b0;
      r_h_write <= 1'b0;
      r_h_unsigned <= 1'b0;
      r_hold0 <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_pair) begin
        r_h_pc <= s1_pc;
        r_h_addr <= s1_addr;
        r_h_wdata <= s1_wdata;
        r_h_width <= s1_width;
        r_h_read <= s1_read;
        r_h_write <= s1_write;
        r_h_unsigned <= s1_unsigned;
        r_hold0 <= (s0_read & !s0_write) ? m_rdata : '0;
        if (r_cnt != '1) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_dmem_dual_issue_arbiter.sv
// tb_dmem_dual_issue_arbiter: table-driven per-cycle vectors against a word memory model, plus a saturating-counter instance
module tb_dmem_dual_issue_arbiter;
  typedef struct {
    logic rst;
    logic [1:0] op0;
    logic [31:0] a0, d0;
    logic [1:0] op1;
    logic [31:0] a1, d1;
    logic st;
    logic [1:0] mop;
    logic i1;
    logic [31:0] addr, wd, r0, r1;
    int cnt;
  } vec_t;

  logic clk = 0, rst = 1;
  logic [31:0] s0_pc = 0, s0_addr = 0, s0_wdata = 0, s1_pc = 0, s1_addr = 0, s1_wdata = 0;
  logic s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
  logic [1:0] s0_width = 2'b10, s1_width = 2'b01;
  logic s0_unsigned = 0, s1_unsigned = 1;
  logic [31:0] m_pc, m_addr, m_wdata, m_rdata, s0_rdata, s1_rdata;
  logic m_read, m_write, m_unsigned, m_is_inst1, stall;
  logic [1:0] m_width;
  logic [31:0] conflict_cnt;
  logic [31:0] b_pc, b_addr, b_wdata, b_s0_rdata, b_s1_rdata;
  logic b_read, b_write, b_unsigned, b_is_inst1, b_stall;
  logic [1:0] b_width;
  logic [1:0] b_cnt;
  logic [31:0] mem [0:255];
  int n_vec = 0, n_cmp = 0, n_bad = 0;
  vec_t tbl [$];
  vec_t sb [$];

  always #5 clk = ~clk;

  dmem_dual_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_pc(s0_pc), .s0_read(s0_read), .s0_write(s0_write), .s0_width(s0_width),
    .s0_unsigned(s0_unsigned), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s1_pc(s1_pc), .s1_read(s1_read), .s1_write(s1_write), .s1_width(s1_width),
    .s1_unsigned(s1_unsigned), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .m_pc(m_pc), .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_width(m_width),
    .m_unsigned(m_unsigned), .m_wdata(m_wdata), .m_is_inst1(m_is_inst1), .m_rdata(m_rdata),
    .s0_rdata(s0_rdata), .s1_rdata(s1_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
  );

  dmem_dual_issue_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .s0_pc(s0_pc), .s0_read(s0_read), .s0_write(s0_write), .s0_width(s0_width),
    .s0_unsigned(s0_unsigned), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s1_pc(s1_pc), .s1_read(s1_read), .s1_write(s1_write), .s1_width(s1_width),
    .s1_unsigned(s1_unsigned), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .m_pc(b_pc), .m_addr(b_addr), .m_read(b_read), .m_write(b_write), .m_width(b_width),
    .m_unsigned(b_unsigned), .m_wdata(b_wdata), .m_is_inst1(b_is_inst1), .m_rdata(m_rdata),
    .s0_rdata(b_s0_rdata), .s1_rdata(b_s1_rdata), .stall(b_stall), .conflict_cnt(b_cnt)
  );

  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_write) mem[m_addr[9:2]] <= m_wdata;

  function automatic vec_t v(logic r, logic [1:0] op0, logic [31:0] a0, d0, logic [1:0] op1,
      logic [31:0] a1, d1, logic st, logic [1:0] mop, logic i1, logic [31:0] addr, wd, r0, r1, int cnt);
    vec_t x;
    x.rst = r; x.op0 = op0; x.a0 = a0; x.d0 = d0; x.op1 = op1; x.a1 = a1; x.d1 = d1;
    x.st = st; x.mop = mop; x.i1 = i1; x.addr = addr; x.wd = wd; x.r0 = r0; x.r1 = r1; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(int idx, string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s got %h expected %h", idx, name, act, exp);
    end
  endtask

  initial begin
    logic act;
    vec_t e;
    for (int i = 0; i < 256; i++) mem[i] = 0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h08] = 32'h11111111;
    mem[8'h09] = 32'h22222222;
    mem[8'h18] = 32'h66666666;
    // op = {read, write}; mop = {m_read, m_write}
    tbl.push_back(v(1, 2'b10, 32'h20, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 2'b10, 32'h10, 0, 0, 2'b10, 1, 32'h10, 0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(v(0, 2'b10, 32'h20, 0, 2'b10, 32'h24, 0, 1, 2'b10, 0, 32'h20, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b10, 32'h10, 0, 2'b01, 32'h60, 32'h99, 0, 2'b10, 1, 32'h24, 0, 32'h11111111, 32'h22222222, 1));
    tbl.push_back(v(0, 2'b01, 32'h40, 32'hCAFEF00D, 2'b10, 32'h40, 0, 1, 2'b01, 0, 32'h40, 32'hCAFEF00D, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 32'h40, 0, 0, 32'hCAFEF00D, 2));
    tbl.push_back(v(0, 2'b01, 32'h50, 1, 2'b01, 32'h50, 2, 1, 2'b01, 0, 32'h50, 1, 0, 0, 2));
    tbl.push_back(v(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b01, 1, 32'h50, 2, 0, 0, 3));
    tbl.push_back(v(0, 2'b10, 32'h50, 0, 2'b00, 0, 0, 0, 2'b10, 0, 32'h50, 0, 2, 0, 3));
    tbl.push_back(v(0, 2'b10, 32'h60, 0, 2'b01, 32'h60, 32'h77, 1, 2'b10, 0, 32'h60, 0, 0, 0, 3));
    tbl.push_back(v(1, 2'b10, 32'h60, 0, 2'b01, 32'h60, 32'h77, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b10, 32'h60, 0, 2'b00, 0, 0, 0, 2'b10, 0, 32'h60, 0, 32'h66666666, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h70, 5, 2'b10, 32'h70, 0, 1, 2'b01, 0, 32'h70, 5, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 32'h70, 0, 0, 5, 1));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(v(0, 2'b10, 32'h10, 0, 2'b10, 32'h20, 0, 1, 2'b10, 0, 32'h10, 0, 0, 0, 1 + k));
      tbl.push_back(v(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 32'h20, 0, 32'hDEADBEEF, 32'h11111111, 2 + k));
    end
    tbl.push_back(v(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      {s0_read, s0_write} = tbl[i].op0; s0_addr = tbl[i].a0; s0_wdata = tbl[i].d0; s0_pc = 32'h1000 + tbl[i].a0;
      {s1_read, s1_write} = tbl[i].op1; s1_addr = tbl[i].a1; s1_wdata = tbl[i].d1; s1_pc = 32'h2000 + tbl[i].a1;
      sb.push_back(tbl[i]);
      n_vec++;
      #1;
      e = sb.pop_front();
      act = e.mop != 2'b00;
      chk(i, "stall", 32'(stall), 32'(e.st));
      chk(i, "m_read", 32'(m_read), 32'(e.mop[1]));
      chk(i, "m_write", 32'(m_write), 32'(e.mop[0]));
      chk(i, "m_is_inst1", 32'(m_is_inst1), 32'(e.i1));
      chk(i, "m_addr", m_addr, e.addr);
      chk(i, "m_wdata", m_wdata, e.wd);
      chk(i, "m_pc", m_pc, act ? (e.i1 ? 32'h2000 : 32'h1000) + e.addr : 32'h0);
      chk(i, "m_width", 32'(m_width), act ? (e.i1 ? 32'h1 : 32'h2) : 32'h0);
      chk(i, "m_unsigned", 32'(m_unsigned), 32'(act & e.i1));
      chk(i, "s0_rdata", s0_rdata, e.r0);
      chk(i, "s1_rdata", s1_rdata, e.r1);
      chk(i, "conflict_cnt", conflict_cnt, 32'(e.cnt));
      chk(i, "conflict_cnt_sat", 32'(b_cnt), 32'(e.cnt > 3 ? 3 : e.cnt));
    end
    @(negedge clk);
    chk(99, "mem_0x50", mem[8'h14], 32'h2);
    chk(99, "mem_0x60_untouched", mem[8'h18], 32'h66666666);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_dual_issue_arbiter.md
Name: dmem_dual_issue_arbiter

Overview:
- Shares the single-port data memory between the two MEM-stage issue slots of the dual-issue pipeline.
- Slot 0 is always older than slot 1.
- When both slots request in the same cycle, the block serializes them in program order across two cycles and stalls the pipeline for one cycle.
- Also holds slot-0 read data across the stall and keeps a saturating conflict counter for performance debug.

Parameters:
CNT_W, 32, width of conflict performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s0_pc  in  32  slot-0 instruction PC
s0_read  in  1  slot-0 load request
s0_write  in  1  slot-0 store request
s0_width  in  2  00 byte, 01 halfword, 10 word
s0_unsigned  in  1  slot-0 zero-extend load
s0_addr  in  32  slot-0 byte address
s0_wdata  in  32  slot-0 store data
s1_pc, s1_read, s1_write, s1_width, s1_unsigned, s1_addr, s1_wdata  in  same widths as slot 0  slot-1 request
m_pc  out  32  PC to memory (debug print)
m_addr  out  32  memory byte address
m_read  out  1  memory read enable
m_write  out  1  memory write enable
m_width  out  2  memory access width
m_unsigned  out  1  memory load extension
m_wdata  out  32  memory store data
m_is_inst1  out  1  1 when slot-1 access is on the port
m_rdata  in  32  memory read data, combinational from m_* inputs
s0_rdata  out  32  slot-0 load result
s1_rdata  out  32  slot-1 load result
stall  out  1  hold IF..MEM stage registers this cycle
conflict_cnt  out  CNT_W  number of serialized (two-cycle) pairs, saturating

Behaviour:
- Slot N is active when sN_read or sN_write is set. If both are set, the write wins: m_read=0 and m_write=1 for that slot.
- FSM has two states, IDLE and SECOND. Reset state is IDLE.
- IDLE, neither slot active:
  - all m_* outputs 0
  - s0_rdata = s1_rdata = 0
  - stall = 0
- IDLE, exactly one slot active:
  - that slot drives m_*; m_is_inst1 = 1 if it is slot 1
  - its rdata = m_rdata for a load, 0 for a store; the other rdata = 0
  - stall = 0; stay in IDLE
- IDLE, both slots active:
  - slot 0 drives m_*; stall = 1
  - at posedge: latch the complete slot-1 request into a hold register
  - at posedge: hold0 <= m_rdata if slot 0 is a load, else 0
  - at posedge: conflict_cnt += 1, saturating at all-ones; go to SECOND
  - s0_rdata / s1_rdata during this cycle are don't-care, bench checks 0
- SECOND:
  - the latched slot-1 request drives m_*; m_is_inst1 = 1
  - live s0_*/s1_* inputs are ignored
  - s0_rdata = hold0
  - s1_rdata = m_rdata for a load, else 0
  - stall = 0; at posedge go to IDLE
- A slot-0 store commits at the IDLE posedge, so a slot-1 load of the same word in SECOND returns the new data (RAW within a pair).
- For a pair of stores, memory write order is slot 0 then slot 1, so on the same address slot 1 wins.
- Latency:
  - single request: 0 extra cycles
  - pair: exactly 1 stall cycle
  - rdata outputs are valid in the cycle where stall = 0
- Unaligned and width handling is delegated to the memory; the arbiter passes width, unsigned and addr unmodified.
- Reset at any time, including in SECOND:
  - next state IDLE
  - hold register and hold0 <= 0
  - conflict_cnt <= 0
  - a pending slot-1 access is dropped (the pipeline is flushed by the same reset)
- Reset outputs:
  - stall, m_read, m_write, m_is_inst1 = 0
  - s0_rdata, s1_rdata = 0
  - conflict_cnt = 0
- Outputs are combinational from state, hold registers and live inputs; no registered m_* outputs.

Test Plan:
- Reset, then idle inputs -> stall=0, m_read=m_write=0, conflict_cnt=0, s0_rdata=s1_rdata=0.
- Only s1 load lw at addr 0x10, memory word 0xDEADBEEF -> same cycle: m_is_inst1=1, m_addr=0x10, s1_rdata=0xDEADBEEF, stall=0, s0_rdata=0, counter stays 0.
- s0 lw 0x20 (=0x11111111) and s1 lw 0x24 (=0x22222222) -> cycle 1: stall=1, m_addr=0x20, m_is_inst1=0. Cycle 2: stall=0, m_addr=0x24, m_is_inst1=1, s0_rdata=0x11111111, s1_rdata=0x22222222, conflict_cnt=1.
- s0 sw 0xCAFEF00D to 0x40, s1 lw 0x40 same cycle -> cycle 1: m_write=1. Cycle 2: s1_rdata=0xCAFEF00D, s0_rdata=0.
- Both sw to 0x50, slot 0 data 0x1, slot 1 data 0x2 -> memory[0x50]=0x2 after cycle 2; write print order slot 0 then slot 1.
- Conflict pair, rst asserted in SECOND -> next cycle IDLE, m_write=0, hold0=0, conflict_cnt=0, slot-1 access never issued.
- Optional, CNT_W=2: four conflict pairs -> conflict_cnt saturates at 3.
